// File: rtl/uart_bus_pkg.sv
// Shared constants and state encoding for the UART-to-bus debug bridge.
package uart_bus_pkg;

    localparam logic [7:0] OP_WR  = 8'h57;
    localparam logic [7:0] OP_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/uart_bus_master_if.sv
// Bus-side signals of the bridge: arbitration handshake plus single-word strobed access.
interface uart_bus_master_if;

    logic        bus_req;
    logic        bus_gnt;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output bus_req, rd, wr, addr, wdata,
        input  bus_gnt, rdata
    );

    modport slave (
        input  bus_req, rd, wr, addr, wdata,
        output bus_gnt, rdata
    );

endinterface

// File: rtl/uart_bus_timeout.sv
// Inter-byte timeout counter: counts while enabled, flags expiry on its last cycle.
module uart_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a held enable cannot wrap into a false restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/uart_bus_master.sv
// UART command-frame to single-word bus access bridge; second bus initiator beside the CPU.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    output logic               tx_valid,
    output logic [7:0]         tx_byte,
    input  logic               tx_ready,
    uart_bus_master_if.master  bus,
    output logic               busy
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [1:0]  rd_left;
    logic        is_write;
    logic [31:0] addr_sr;
    logic [31:0] wdata_sr;
    logic [31:0] rd_sr;
    logic [7:0]  tx_byte_q;
    logic        expire;
    logic        timeout_enable;
    logic        timeout_clear;
    logic        tx_fire;
    logic        valid_op;

    assign timeout_enable = (state == ADDR) || (state == DATA);
    assign timeout_clear  = rx_valid || !timeout_enable;
    assign tx_fire        = (state == RESP) && tx_ready;
    assign valid_op       = (rx_byte == OP_WR) || (rx_byte == OP_RD);

    uart_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timeout_clear),
        .enable (timeout_enable),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A received byte always beats a timeout expiring in the same cycle.
    always_comb begin
        next_state = state;
        bus.bus_req = 1'b0;
        bus.rd      = 1'b0;
        bus.wr      = 1'b0;
        tx_valid    = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (rx_valid) begin
                    next_state = valid_op ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) begin
                        next_state = is_write ? DATA : REQ;
                    end
                end else if (expire) begin
                    next_state = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) begin
                        next_state = REQ;
                    end
                end else if (expire) begin
                    next_state = IDLE;
                end
            end
            REQ: begin
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                bus.bus_req = 1'b1;
                bus.rd      = !is_write;
                bus.wr      = is_write;
                next_state  = RESP;
            end
            RESP: begin
                tx_valid = 1'b1;
                if (tx_fire && (rd_left == 2'd0)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame assembly, read capture and response sequencing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            rd_left   <= 2'd0;
            is_write  <= 1'b0;
            addr_sr   <= 32'd0;
            wdata_sr  <= 32'd0;
            rd_sr     <= 32'd0;
            tx_byte_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        is_write <= (rx_byte == OP_WR);
                        byte_cnt <= 2'd0;
                        if (!valid_op) begin
                            tx_byte_q <= RSP_ERR;
                            rd_left   <= 2'd0;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_sr  <= {addr_sr[23:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                    end else if (expire) begin
                        byte_cnt <= 2'd0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        wdata_sr <= {wdata_sr[23:0], rx_byte};
                        byte_cnt <= byte_cnt + 2'd1;
                    end else if (expire) begin
                        byte_cnt <= 2'd0;
                    end
                end
                ACCESS: begin
                    if (is_write) begin
                        tx_byte_q <= RSP_OK;
                        rd_left   <= 2'd0;
                    end else begin
                        rd_sr     <= bus.rdata;
                        tx_byte_q <= bus.rdata[31:24];
                        rd_left   <= 2'd3;
                    end
                end
                RESP: begin
                    if (tx_fire && (rd_left != 2'd0)) begin
                        tx_byte_q <= rd_sr[23:16];
                        rd_sr     <= {rd_sr[23:0], 8'h00};
                        rd_left   <= rd_left - 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.addr  = {addr_sr[31:2], 2'b00};
    assign bus.wdata = wdata_sr;
    assign tx_byte   = tx_byte_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: expected accesses and tx bytes queued at stimulus time.
module tb_uart_bus_master;
    import uart_bus_pkg::*;

    localparam int TO    = 40;
    localparam int CNT_W = 6;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        busy;
    logic        bus_gnt;
    logic [31:0] rd_value;

    int error_count;
    int check_count;

    acc_t       exp_acc[$];
    logic [7:0] exp_tx[$];
    acc_t       mon_acc;
    logic [7:0] mon_tx;

    uart_bus_master_if bus_if ();

    assign bus_if.bus_gnt = bus_gnt;
    assign bus_if.rdata   = rd_value;

    uart_bus_master #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tx_valid (tx_valid),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready),
        .bus      (bus_if),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One rx_valid pulse; entered and left at posedge+1.
    task automatic applyStimulus(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic sendAddr(input logic [31:0] a);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(a[i*8 +: 8]);
        end
    endtask

    task automatic sendWrite(input logic [31:0] a, input logic [31:0] d);
        acc_t e;
        e.is_write = 1'b1;
        e.addr     = {a[31:2], 2'b00};
        e.wdata    = d;
        exp_acc.push_back(e);
        exp_tx.push_back(RSP_OK);
        applyStimulus(OP_WR);
        sendAddr(a);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(d[i*8 +: 8]);
        end
    endtask

    task automatic expectRead(input logic [31:0] a, input logic [31:0] d);
        acc_t e;
        e.is_write = 1'b0;
        e.addr     = {a[31:2], 2'b00};
        e.wdata    = 32'd0;
        exp_acc.push_back(e);
        for (int i = 3; i >= 0; i--) begin
            exp_tx.push_back(d[i*8 +: 8]);
        end
    endtask

    task automatic sendRead(input logic [31:0] a, input logic [31:0] d);
        rd_value = d;
        expectRead(a, d);
        applyStimulus(OP_RD);
        sendAddr(a);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_tx.size() != 0 || exp_acc.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pending"}, 32'(exp_tx.size() + exp_acc.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe and every tx transfer is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.rd || bus_if.wr) begin
                checkOutput("rd_wr_excl", 32'(bus_if.rd && bus_if.wr), 32'd0);
                checkOutput("req_in_access", 32'(bus_if.bus_req), 32'd1);
                if (exp_acc.size() == 0) begin
                    checkOutput("unexp_strobe", {30'd0, bus_if.rd, bus_if.wr}, 32'd0);
                end else begin
                    mon_acc = exp_acc.pop_front();
                    checkOutput("acc_kind", 32'(bus_if.wr), 32'(mon_acc.is_write));
                    checkOutput("acc_addr", bus_if.addr, mon_acc.addr);
                    if (mon_acc.is_write) begin
                        checkOutput("acc_wdata", bus_if.wdata, mon_acc.wdata);
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checkOutput("unexp_tx", 32'(tx_valid), 32'd0);
                end else begin
                    mon_tx = exp_tx.pop_front();
                    checkOutput("tx_byte", 32'(tx_byte), 32'(mon_tx));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [7:0] held;
        logic [7:0] frame[5];

        error_count = 0;
        check_count = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_ready = 1'b1;
        bus_gnt  = 1'b1;
        rd_value = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_byte", 32'(tx_byte), 32'd0);
        checkOutput("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        checkOutput("rst_rd", 32'(bus_if.rd), 32'd0);
        checkOutput("rst_wr", 32'(bus_if.wr), 32'd0);
        checkOutput("rst_addr", bus_if.addr, 32'd0);
        checkOutput("rst_wdata", bus_if.wdata, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] write frame");
        sendWrite(32'h4000000C, 32'h000000A5);
        waitIdle("write");

        $display("[TB] read frame with latency checks");
        sendRead(32'h40000010, 32'h12345678);
        @(negedge clk);
        checkOutput("lat_req", 32'(bus_if.bus_req), 32'd1);
        checkOutput("lat_no_rd_yet", 32'(bus_if.rd), 32'd0);
        @(negedge clk);
        checkOutput("lat_rd", 32'(bus_if.rd), 32'd1);
        checkOutput("lat_no_tx_yet", 32'(tx_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("lat_req_drop", 32'(bus_if.bus_req), 32'd0);
        waitIdle("read");

        $display("[TB] grant held off");
        bus_gnt = 1'b0;
        sendWrite(32'h40000020, 32'hDEADBEEF);
        repeat (50) begin
            @(negedge clk);
            checkOutput("req_hold", 32'(bus_if.bus_req), 32'd1);
            checkOutput("no_strobe", {30'd0, bus_if.rd, bus_if.wr}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(negedge clk);
        checkOutput("gnt_not_early", 32'(bus_if.wr), 32'd0);
        @(negedge clk);
        checkOutput("gnt_to_wr", 32'(bus_if.wr), 32'd1);
        waitIdle("grant");

        $display("[TB] tx backpressure");
        tx_ready = 1'b0;
        sendRead(32'h40000030, 32'hCAFEF00D);
        n = 0;
        @(negedge clk);
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_tx_valid", 32'(tx_valid), 32'd1);
        held = tx_byte;
        checkOutput("bp_first_byte", 32'(held), 32'h000000CA);
        repeat (20) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(tx_valid), 32'd1);
            checkOutput("bp_hold_byte", 32'(tx_byte), 32'(held));
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        waitIdle("backpressure");

        $display("[TB] bad opcode and alignment");
        exp_tx.push_back(RSP_ERR);
        applyStimulus(8'h41);
        waitIdle("bad_op");
        sendRead(32'h00000007, 32'hA1B2C3D4);
        waitIdle("align");

        $display("[TB] timeout abort");
        applyStimulus(OP_WR);
        applyStimulus(8'h40);
        applyStimulus(8'h00);
        repeat (TO - 1) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("to_still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("to_aborted", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("to_no_tx", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
        sendRead(32'h40000018, 32'h0BADF00D);
        waitIdle("after_to");

        $display("[TB] byte on expiry cycle");
        frame[0] = OP_RD;
        frame[1] = 8'h40;
        frame[2] = 8'h00;
        frame[3] = 8'h00;
        frame[4] = 8'h14;
        rd_value = 32'h55AA33CC;
        expectRead(32'h40000014, 32'h55AA33CC);
        applyStimulus(frame[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (TO - 1) @(posedge clk);
            #1;
            applyStimulus(frame[i]);
        end
        waitIdle("expiry_byte");

        $display("[TB] reset during access");
        bus_gnt = 1'b0;
        rd_value = 32'h11111111;
        begin
            acc_t e;
            e.is_write = 1'b0;
            e.addr     = 32'h40000040;
            e.wdata    = 32'd0;
            exp_acc.push_back(e);
        end
        applyStimulus(OP_RD);
        sendAddr(32'h40000040);
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rd_high", 32'(bus_if.rd), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_rd_drop", 32'(bus_if.rd), 32'd0);
        checkOutput("mid_wr_drop", 32'(bus_if.wr), 32'd0);
        checkOutput("mid_req_drop", 32'(bus_if.bus_req), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("mid_tx_byte", 32'(tx_byte), 32'd0);
        checkOutput("mid_addr", bus_if.addr, 32'd0);
        checkOutput("mid_wdata", bus_if.wdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post_rst_idle", 32'(busy), 32'd0);
        checkOutput("post_rst_pending", 32'(exp_tx.size() + exp_acc.size()), 32'd0);
        @(posedge clk);
        #1;
        sendWrite(32'h40000050, 32'h01020304);
        waitIdle("recover");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Debug/boot bridge. Turns command frames from the UART receiver into single-word bus reads and writes on the CPU data bus, as a second bus initiator beside the CPU.
- Drives rd/wr/addr/wdata into the same address space as the peripheral and data memory. Returns results through the UART transmitter.
- Takes the bus only after an arbiter grant. The CPU is held while this block owns the bus.

Parameters:
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one frame before the frame is aborted.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse: rx_byte holds a newly received byte.
- rx_byte  in  8  received byte.
- tx_valid  out  1  tx_byte is valid; held until accepted.
- tx_byte  out  8  byte to transmit.
- tx_ready  in  1  transmitter can accept; a transfer occurs when tx_valid and tx_ready are both 1 on a rising clk edge.
- bus_req  out  1  request for bus ownership.
- bus_gnt  in  1  arbiter grant.
- rd  out  1  bus read strobe.
- wr  out  1  bus write strobe.
- addr  out  32  bus address; bits [1:0] are always 0.
- wdata  out  32  bus write data.
- rdata  in  32  bus read data, combinational, valid in the same cycle as rd.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; tx_valid, tx_byte, bus_req, rd, wr, addr, wdata, busy, byte counter and timeout counter all 0. Reset in mid-frame or mid-access aborts immediately. rd/wr fall asynchronously and nothing is transmitted.
- Frame format: opcode byte, then 4 address bytes MSB first. Opcode 0x57 ('W') is followed by 4 data bytes MSB first. Opcode 0x52 ('R') has no data bytes.
- Responses:
  - 'W' returns 0x4B ('K').
  - 'R' returns the 4 rdata bytes, MSB first.
  - Any other opcode returns 0x3F ('?').
- Assembled address is taken as {a[31:2],2'b00}; the low 2 bits of the last address byte are ignored.
- States:
  - IDLE: on rx_valid, decode the opcode. 'R'/'W' -> ADDR with byte count 0. Other -> RESP with tx_byte=0x3F.
  - ADDR: each rx_valid shifts a byte into addr. After the 4th byte: 'W' -> DATA, 'R' -> REQ.
  - DATA: each rx_valid shifts a byte into wdata. After the 4th byte -> REQ.
  - REQ: bus_req=1. Stays here while bus_gnt=0, with no timeout. When bus_gnt=1 is sampled -> ACCESS.
  - ACCESS: exactly one cycle. bus_req=1 and rd or wr=1. For a read, rdata is captured into a 32-bit shift register at the end of this cycle. Then -> RESP with tx_byte=0x4B for a write, or rdata[31:24] for a read. bus_req drops on the next cycle.
  - RESP: tx_valid=1. On transfer: send the next rdata byte if read bytes remain; otherwise tx_valid=0 and -> IDLE.
- Latency:
  - Last frame byte to bus_req=1: 1 cycle.
  - bus_gnt sampled high to rd/wr pulse: 1 cycle.
  - Strobe to tx_valid=1: 1 cycle.
- rd and wr are never high together. Each is high for exactly one cycle per frame. Both are 0 outside ACCESS.
- Timeout:
  - Counter runs only in ADDR and DATA. It clears on entry to those states and on every rx_valid.
  - On reaching TIMEOUT_CYCLES-1 without rx_valid: -> IDLE silently, with no bus access and no response.
  - If rx_valid arrives in the same cycle the counter expires, the byte wins: it is accepted and the counter clears.
- rx_valid in REQ, ACCESS or RESP: the byte is dropped, with no other effect.
- tx_ready low during RESP: tx_valid and tx_byte hold their values indefinitely, with no timeout.
- addr/wdata keep their last values in IDLE. Only the rd/wr strobes qualify them.

Decomposition:
- Shared package uart_bus_pkg:
  - Opcode constants OP_WR=8'h57, OP_RD=8'h52.
  - Response constants RSP_OK=8'h4B, RSP_ERR=8'h3F.
  - State encoding typedef {IDLE,ADDR,DATA,REQ,ACCESS,RESP}.
- One natural sub-module: uart_bus_timeout, the inter-byte timeout counter with clear/enable inputs and an expire output.
- The FSM and shift registers stay in the top module.

Test Plan:
- Write: rx 57 40 00 00 0C 00 00 00 A5, bus_gnt tied 1 -> one wr pulse with addr=0x4000000C, wdata=0x000000A5; tx 0x4B; busy back to 0.
- Read: rx 52 40 00 00 10, rdata=0x12345678 during the rd cycle -> one rd pulse with addr=0x40000010; tx 12 34 56 78 in order.
- Grant and backpressure: bus_gnt held 0 for 50 cycles -> bus_req held, no strobe, no timeout; access occurs 1 cycle after the grant. tx_ready held 0 for 20 cycles -> tx_byte stable throughout.
- Bad opcode and alignment: rx 0x41 -> tx 0x3F, no bus activity. rx 52 00 00 00 07 -> rd with addr=0x00000004.
- Timeout: rx 57 40 00, then silence for TIMEOUT_CYCLES -> return to IDLE with no wr and no tx. A following full 'R' frame is serviced normally. A byte arriving exactly on the expiry cycle is accepted.
- Reset mid-op: assert reset during the ACCESS cycle -> rd/wr drop immediately, no tx, all outputs 0, state IDLE.
